// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: default widths, requester indices, and a source-width helper.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_N_REQ     = 3;
  localparam int unsigned CDB_ROB_IDX_W = 5;
  localparam int unsigned CDB_DATA_W    = 32;

  localparam int unsigned CDB_SRC_LSB  = 0;
  localparam int unsigned CDB_SRC_ALU0 = 1;
  localparam int unsigned CDB_SRC_ALU1 = 2;

  // Width of an encoded requester index; never narrower than one bit
  function automatic int unsigned cdb_src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side and broadcast-side signals of the CDB arbiter.
// master = functional units / bus users, slave = the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = CDB_N_REQ,
  parameter int unsigned ROB_IDX_W = CDB_ROB_IDX_W,
  parameter int unsigned DATA_W    = CDB_DATA_W
);
  localparam int unsigned SRC_W = cdb_src_w(N_REQ);

  logic [N_REQ-1:0]           req_valid_in;
  logic [N_REQ*ROB_IDX_W-1:0] req_rob_id_in;
  logic [N_REQ*DATA_W-1:0]    req_value_in;
  logic [N_REQ-1:0]           req_ready_out;
  logic                       cdb_valid_out;
  logic [ROB_IDX_W-1:0]       cdb_rob_id_out;
  logic [DATA_W-1:0]          cdb_value_out;
  logic [SRC_W-1:0]           cdb_src_out;

  modport master (
    output req_valid_in, req_rob_id_in, req_value_in,
    input  req_ready_out, cdb_valid_out, cdb_rob_id_out, cdb_value_out, cdb_src_out
  );

  modport slave (
    input  req_valid_in, req_rob_id_in, req_value_in,
    output req_ready_out, cdb_valid_out, cdb_rob_id_out, cdb_value_out, cdb_src_out
  );

endinterface

// File: rtl/cdb_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping explicitly
// so non-power-of-two requester counts work.
module rr_grant #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned SRC_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any_o && req_i[SRC_W'(cand)]) begin
        any_o                = 1'b1;
        idx_o                = SRC_W'(cand);
        gnt_o[SRC_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus; winner is registered onto the broadcast bus.
// Optional CDB_LSB_PRIORITY_EN: requester 0 (LSB) always wins and does not move the pointer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = CDB_N_REQ,
  parameter int unsigned ROB_IDX_W = CDB_ROB_IDX_W,
  parameter int unsigned DATA_W    = CDB_DATA_W
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  cdb_arbiter_if.slave  bus_if
);

  localparam int unsigned SRC_W = cdb_src_w(N_REQ);

  logic [N_REQ-1:0]     rr_req;
  logic [N_REQ-1:0]     rr_gnt;
  logic [SRC_W-1:0]     rr_idx;
  logic                 rr_any;
  logic                 lsb_win;

  logic [N_REQ-1:0]     win_gnt;
  logic [SRC_W-1:0]     win_idx;
  logic                 win_any;
  logic                 gate;
  logic                 accept;
  int unsigned          sel;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0] cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0]    cdb_value_q, cdb_value_d;
  logic [SRC_W-1:0]     cdb_src_q,   cdb_src_d;
  logic [SRC_W-1:0]     rr_ptr_q,    rr_ptr_d;

`ifdef CDB_LSB_PRIORITY_EN
  // LSB bypasses the rotation; the others share the pointer among themselves
  assign lsb_win = bus_if.req_valid_in[0];
  assign rr_req  = {bus_if.req_valid_in[N_REQ-1:1], 1'b0};
`else
  assign lsb_win = 1'b0;
  assign rr_req  = bus_if.req_valid_in;
`endif

  rr_grant #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_rr_grant (
    .req_i (rr_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    gate        = rdy_in & ~flush_in & ~rst_in;
    win_gnt     = lsb_win ? N_REQ'(1) : rr_gnt;
    win_idx     = lsb_win ? '0 : rr_idx;
    win_any     = lsb_win | rr_any;
    accept      = gate & win_any;
    sel         = 32'(win_idx);
    bus_if.req_ready_out = gate ? win_gnt : '0;

    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;

    // Everything freezes while rdy_in is low; flush clears the pulse and pointer
    if (rdy_in) begin
      cdb_valid_d = accept;
      if (flush_in) begin
        rr_ptr_d = '0;
      end else if (accept) begin
        cdb_tag_d   = bus_if.req_rob_id_in[sel*ROB_IDX_W +: ROB_IDX_W];
        cdb_value_d = bus_if.req_value_in[sel*DATA_W +: DATA_W];
        cdb_src_d   = win_idx;
        if (!lsb_win)
          rr_ptr_d = (sel == N_REQ - 1) ? '0 : win_idx + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus_if.cdb_valid_out  = cdb_valid_q;
  assign bus_if.cdb_rob_id_out = cdb_tag_q;
  assign bus_if.cdb_value_out  = cdb_value_q;
  assign bus_if.cdb_src_out    = cdb_src_q;

endmodule
